mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 No parameters; memory-bus data width fixed at 8 bits, address width fixed at 32 bits.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  bus grant; low = bus owned by host debug interface, controller paused.
REQ-005 clr_in  input  1  pipeline flush; aborts an in-flight instruction fetch.
REQ-006 if_req_in  input  1  instruction-fetch request, level, held until if_done_out.
REQ-007 if_addr_in  input  32  fetch address; always a 4-byte word read.
REQ-008 if_done_out  output  1  one-cycle pulse; if_data_out valid this cycle.
REQ-009 if_data_out  output  32  fetched word, little-endian.
REQ-010 ls_req_in  input  1  load/store request, level, held until ls_done_out.
REQ-011 ls_wr_in  input  1  1 = store, 0 = load.
REQ-012 ls_size_in  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-013 ls_addr_in  input  32  load/store byte address; no alignment requirement.
REQ-014 ls_wdata_in  input  32  store data; low n bytes used.
REQ-015 ls_done_out  output  1  one-cycle pulse; load data valid / store complete.
REQ-016 ls_rdata_out  output  32  load data, zero-extended above n bytes.
REQ-017 mem_din  input  8  byte read from bus, valid one cycle after its address.
REQ-018 mem_dout  output  8  byte to write.
REQ-019 mem_a  output  32  byte address.
REQ-020 mem_wr  output  1  1 = write this cycle.

Function
REQ-021 States: IDLE, READ, WRITE; n = byte count of accepted request (1/2/4).
REQ-022 IDLE acceptance: ls_req_in beats if_req_in when both are high; if_req_in is not accepted in a cycle with clr_in high.
REQ-023 Read: addresses A+0..A+n-1 on mem_a in cycles 1..n after the accept edge; byte k is captured from mem_din in cycle k+2 into bits [8k+7:8k]; done pulses in cycle n+2; return to IDLE on that edge.
REQ-024 Write: mem_a=A+k, mem_dout=wdata[8k+7:8k], mem_wr=1 in cycle k+1; ls_done_out pulses in cycle n+1.
REQ-025 Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFF+1 wraps to 0.
REQ-026 In IDLE, mem_a=0, mem_wr=0, and mem_dout=0; done outputs are never high in two consecutive cycles.
REQ-027 Data outputs hold their last value between done pulses.
REQ-028 clr_in high during an ifetch READ: return to IDLE on the next edge, no if_done_out, mem_wr stays 0.
REQ-029 clr_in during a load or store: ignored; the access always completes.
REQ-030 rdy_in low: all state holds and mem_wr is forced to 0; a byte counts as issued only if rdy_in was high in its address cycle, and data is captured only if rdy_in is high in the capture cycle.
REQ-031 Resume after rdy_in low: re-issue starting at the first byte not yet captured (read) or not yet written (write); no byte is duplicated in the result and no byte is lost.
REQ-032 A new request may be accepted in the cycle following a done pulse.

Reset
REQ-033 rst_in asserts state=IDLE and clears mem_a, mem_dout, mem_wr, both done outputs, if_data_out, ls_data_out, and all counters to 0.
REQ-034 Reset mid-access abandons it; no done pulse for the aborted access after release.

Structure
REQ-035 Shared package mem_ctrl_pkg holds the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-036 The block is flat; no sub-module.

Verification
REQ-037 RAM[0x100..0x103]=11 22 33 44; ifetch 0x100 -> if_data_out=0x44332211 in cycle 6, one pulse.
REQ-038 Store half 0xBEEF at 0x201 -> writes EF@0x201 cycle 1, BE@0x202 cycle 2, ls_done cycle 3; later byte load 0x202 -> 0x000000BE.
REQ-039 if_req and ls_req (load word) in the same cycle -> load served first, fetch accepted after ls_done, both correct.
REQ-040 rdy_in low for 3 cycles after the second byte address of a word read -> correct word, each address issued with rdy high exactly once per byte captured.
REQ-041 clr_in in cycle 2 of an ifetch -> IDLE next edge, no if_done; clr_in during a store -> store completes.
REQ-042 rst_in pulsed mid-write -> all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory bus controller: access size
// codes, controller states and small byte-lane helpers.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Index of the last byte of an access; code 11 behaves as a word.
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      SZ_BYTE: r = 2'd0;
      SZ_HALF: r = 2'd1;
      SZ_WORD: r = 2'd3;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Little-endian byte lane k of a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] r;
    case (k)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  // Replace little-endian byte lane k of a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory bus controller: serialises 32-bit instruction fetches and
// byte/half/word loads and stores onto an 8-bit synchronous memory bus.
// Read data returns one cycle after its address; a bus stall (rdy_in low)
// drops any byte in flight, which is re-issued once the bus comes back.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        ls_req_in,
  input  logic        ls_wr_in,
  input  logic [1:0]  ls_size_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_wdata_in,
  output logic        ls_done_out,
  output logic [31:0] ls_rdata_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_t      state;
  logic [31:0] base;       // start address of the current access
  logic [31:0] wdata;      // store data of the current access
  logic [31:0] rbuf;       // read bytes assembled so far (zero above)
  logic [1:0]  last_idx;   // n-1
  logic [1:0]  iss_idx;    // byte index currently on mem_a
  logic        iss_vld;    // mem_a carries a byte still to be issued
  logic [1:0]  pend_idx;   // byte whose data arrives on mem_din this cycle
  logic        pend_vld;
  logic [1:0]  cap_cnt;    // bytes captured so far = first byte not yet captured
  logic        is_if;      // current read is an instruction fetch
  logic        wr_q;

  logic [1:0]  nxt_idx;
  logic [31:0] nxt_a;
  logic [31:0] reissue_a;
  logic [31:0] merged;
  logic        accept_ok;

  // Next-byte address, stall re-issue address and read merge.
  always_comb begin
    nxt_idx   = iss_idx + 2'd1;
    nxt_a     = base + {30'd0, nxt_idx};
    reissue_a = base + {30'd0, cap_cnt};
    merged    = put_byte(rbuf, pend_idx, mem_din);
    // No acceptance in a done cycle: the finished requester still holds its request.
    accept_ok = rdy_in && !if_done_out && !ls_done_out;
  end

  // The bus owner can never see a write strobe while the bus is not granted.
  assign mem_wr = wr_q & rdy_in;

  // Controller FSM with registered bus and result outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      base         <= 32'd0;
      wdata        <= 32'd0;
      rbuf         <= 32'd0;
      last_idx     <= 2'd0;
      iss_idx      <= 2'd0;
      iss_vld      <= 1'b0;
      pend_idx     <= 2'd0;
      pend_vld     <= 1'b0;
      cap_cnt      <= 2'd0;
      is_if        <= 1'b0;
      wr_q         <= 1'b0;
      mem_a        <= 32'd0;
      mem_dout     <= 8'd0;
      if_done_out  <= 1'b0;
      ls_done_out  <= 1'b0;
      if_data_out  <= 32'd0;
      ls_rdata_out <= 32'd0;
    end else begin
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ok && ls_req_in) begin
            base     <= ls_addr_in;
            wdata    <= ls_wdata_in;
            last_idx <= last_index(ls_size_in);
            is_if    <= 1'b0;
            mem_a    <= ls_addr_in;
            iss_idx  <= 2'd0;
            pend_vld <= 1'b0;
            cap_cnt  <= 2'd0;
            rbuf     <= 32'd0;
            if (ls_wr_in) begin
              state    <= WRITE;
              mem_dout <= ls_wdata_in[7:0];
              wr_q     <= 1'b1;
            end else begin
              state    <= READ;
              iss_vld  <= 1'b1;
            end
          end else if (accept_ok && if_req_in && !clr_in) begin
            state    <= READ;
            base     <= if_addr_in;
            last_idx <= 2'd3;
            is_if    <= 1'b1;
            mem_a    <= if_addr_in;
            iss_idx  <= 2'd0;
            iss_vld  <= 1'b1;
            pend_vld <= 1'b0;
            cap_cnt  <= 2'd0;
            rbuf     <= 32'd0;
          end
        end

        READ: begin
          if (is_if && clr_in) begin
            state    <= IDLE;
            mem_a    <= 32'd0;
            iss_idx  <= 2'd0;
            iss_vld  <= 1'b0;
            pend_vld <= 1'b0;
            cap_cnt  <= 2'd0;
          end else if (!rdy_in) begin
            // Any byte in flight is lost; restart from the first uncaptured byte.
            pend_vld <= 1'b0;
            iss_vld  <= 1'b1;
            iss_idx  <= cap_cnt;
            mem_a    <= reissue_a;
          end else begin
            if (pend_vld) begin
              rbuf    <= merged;
              cap_cnt <= cap_cnt + 2'd1;
            end
            if (pend_vld && pend_idx == last_idx) begin
              if (is_if) begin
                if_data_out <= merged;
                if_done_out <= 1'b1;
              end else begin
                ls_rdata_out <= merged;
                ls_done_out  <= 1'b1;
              end
              state    <= IDLE;
              mem_a    <= 32'd0;
              iss_idx  <= 2'd0;
              iss_vld  <= 1'b0;
              pend_vld <= 1'b0;
              cap_cnt  <= 2'd0;
            end else if (iss_vld) begin
              pend_vld <= 1'b1;
              pend_idx <= iss_idx;
              if (iss_idx == last_idx) begin
                iss_vld <= 1'b0;
              end else begin
                iss_idx <= nxt_idx;
                mem_a   <= nxt_a;
              end
            end else begin
              pend_vld <= 1'b0;
            end
          end
        end

        WRITE: begin
          // A byte is written only in a granted cycle; otherwise it is simply held.
          if (rdy_in) begin
            if (iss_idx == last_idx) begin
              ls_done_out <= 1'b1;
              state       <= IDLE;
              mem_a       <= 32'd0;
              mem_dout    <= 8'd0;
              wr_q        <= 1'b0;
              iss_idx     <= 2'd0;
            end else begin
              iss_idx  <= nxt_idx;
              mem_a    <= nxt_a;
              mem_dout <= byte_of(wdata, nxt_idx);
            end
          end
        end

        default: begin
          state <= IDLE;
          mem_a <= 32'd0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
